// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide memory port between an I-cache (reads
// only) and a D-cache (reads and writebacks). Simultaneous requests are
// granted round-robin. The granted transaction is latched so the memory side
// sees stable outputs regardless of what the requesters do meanwhile.
//
// Handshake: a requester holds its read/write level until it sees its
// x_pmem_resp strobe (one cycle, combinational from pmem_resp while that side
// is being served), and drops the request in the following cycle. The memory
// holds pmem_read/pmem_write as a level and answers with a one-cycle
// pmem_resp; read data is valid in that cycle only.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_pmem_read,
    input  logic [ADDR_WIDTH-1:0] inst_pmem_address,
    output logic [LINE_WIDTH-1:0] inst_pmem_rdata,
    output logic                  inst_pmem_resp,
    input  logic                  data_pmem_read,
    input  logic                  data_pmem_write,
    input  logic [ADDR_WIDTH-1:0] data_pmem_address,
    input  logic [LINE_WIDTH-1:0] data_pmem_wdata,
    output logic [LINE_WIDTH-1:0] data_pmem_rdata,
    output logic                  data_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_grant;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_wdata;
    logic                    r_rd;
    logic                    r_wr;

    logic                    w_i_req;
    logic                    w_d_req;
    logic                    w_load_i;
    logic                    w_load_d;
    logic                    w_done;

    assign w_i_req = inst_pmem_read;
    assign w_d_req = data_pmem_read | data_pmem_write;

    // Read data is broadcast; only the completion strobes are steered.
    assign inst_pmem_rdata = pmem_rdata;
    assign data_pmem_rdata = pmem_rdata;

    assign pmem_read    = r_rd;
    assign pmem_write   = r_wr;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign o_dbg_state  = r_state;

    // Next-state, grant selection and completion strobes.
    always_comb begin
        w_next_state   = r_state;
        w_load_i       = 1'b0;
        w_load_d       = 1'b0;
        w_done         = 1'b0;
        inst_pmem_resp = 1'b0;
        data_pmem_resp = 1'b0;
        case (r_state)
            IDLE: begin
                // pmem_resp here belongs to no transaction and is dropped.
                if (w_i_req && w_d_req) begin
                    if (r_last_grant == GRANT_I) w_load_d = 1'b1;
                    else                         w_load_i = 1'b1;
                end else if (w_i_req) begin
                    w_load_i = 1'b1;
                end else if (w_d_req) begin
                    w_load_d = 1'b1;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    w_done         = 1'b1;
                    inst_pmem_resp = 1'b1;
                    // The finishing side still has its request up this cycle,
                    // so only the other side may be chained.
                    if (w_d_req) w_load_d = 1'b1;
                    else         w_next_state = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    w_done         = 1'b1;
                    data_pmem_resp = 1'b1;
                    if (w_i_req) w_load_i = 1'b1;
                    else         w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (w_load_i) w_next_state = SERVE_I;
        if (w_load_d) w_next_state = SERVE_D;
    end

    // State, fairness bit and transaction latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_done) begin
                r_last_grant <= (r_state == SERVE_D) ? GRANT_D : GRANT_I;
            end
            if (w_load_i) begin
                r_addr  <= inst_pmem_address;
                r_wdata <= '0;
                r_rd    <= 1'b1;
                r_wr    <= 1'b0;
            end else if (w_load_d) begin
                // A simultaneous read+write is treated as a writeback.
                r_addr  <= data_pmem_address;
                r_wdata <= data_pmem_wdata;
                r_rd    <= ~data_pmem_write;
                r_wr    <= data_pmem_write;
            end else if (w_done) begin
                // Address/data stay put; only the op levels drop in IDLE.
                r_rd <= 1'b0;
                r_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: per-cycle vector table for the cache_arbiter. Each record
// holds the inputs for one cycle and the outputs expected during that cycle.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    localparam logic [LW-1:0] L_Z  = '0;
    localparam logic [LW-1:0] L_AA = {32{8'hAA}};
    localparam logic [LW-1:0] L_55 = {32{8'h55}};
    localparam logic [LW-1:0] L_CC = {32{8'hCC}};
    localparam logic [LW-1:0] L_33 = {32{8'h33}};
    localparam logic [LW-1:0] L_0F = {32{8'h0F}};
    localparam logic [LW-1:0] L_12 = {8{32'h1234_5678}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SI   = 2'd1;
    localparam logic [1:0] S_SD   = 2'd2;

    typedef struct {
        logic          rst;
        logic          i_rd;
        logic [AW-1:0] i_addr;
        logic          d_rd;
        logic          d_wr;
        logic [AW-1:0] d_addr;
        logic [LW-1:0] d_wdata;
        logic          m_resp;
        logic [LW-1:0] m_rdata;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        logic          e_iresp;
        logic          e_dresp;
        logic [1:0]    e_state;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          inst_pmem_read;
    logic [AW-1:0] inst_pmem_address;
    logic [LW-1:0] inst_pmem_rdata;
    logic          inst_pmem_resp;
    logic          data_pmem_read;
    logic          data_pmem_write;
    logic [AW-1:0] data_pmem_address;
    logic [LW-1:0] data_pmem_wdata;
    logic [LW-1:0] data_pmem_rdata;
    logic          data_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [1:0]    o_dbg_state;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_pmem_read    (inst_pmem_read),
        .inst_pmem_address (inst_pmem_address),
        .inst_pmem_rdata   (inst_pmem_rdata),
        .inst_pmem_resp    (inst_pmem_resp),
        .data_pmem_read    (data_pmem_read),
        .data_pmem_write   (data_pmem_write),
        .data_pmem_address (data_pmem_address),
        .data_pmem_wdata   (data_pmem_wdata),
        .data_pmem_rdata   (data_pmem_rdata),
        .data_pmem_resp    (data_pmem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp),
        .o_dbg_state       (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic rs, input logic ird, input logic [AW-1:0] ia,
        input logic drd, input logic dwr, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
        input logic mr, input logic [LW-1:0] mrd,
        input logic erd, input logic ewr, input logic [AW-1:0] ea, input logic [LW-1:0] ewd,
        input logic eir, input logic edr, input logic [1:0] est);
        vec_t r;
        r.rst = rs;   r.i_rd = ird;  r.i_addr = ia;
        r.d_rd = drd; r.d_wr = dwr;  r.d_addr = da;  r.d_wdata = dwd;
        r.m_resp = mr; r.m_rdata = mrd;
        r.e_rd = erd; r.e_wr = ewr;  r.e_addr = ea;  r.e_wdata = ewd;
        r.e_iresp = eir; r.e_dresp = edr; r.e_state = est;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Driver: apply one record at the falling edge, check outputs 1 ns later.
    task automatic apply(input vec_t r, input int idx);
        @(negedge clk);
        rst               = r.rst;
        inst_pmem_read    = r.i_rd;
        inst_pmem_address = r.i_addr;
        data_pmem_read    = r.d_rd;
        data_pmem_write   = r.d_wr;
        data_pmem_address = r.d_addr;
        data_pmem_wdata   = r.d_wdata;
        pmem_resp         = r.m_resp;
        pmem_rdata        = r.m_rdata;
        #1;
        chk("pmem_read",  idx, LW'(pmem_read),      LW'(r.e_rd));
        chk("pmem_write", idx, LW'(pmem_write),     LW'(r.e_wr));
        chk("pmem_addr",  idx, LW'(pmem_address),   LW'(r.e_addr));
        chk("pmem_wdata", idx, pmem_wdata,          r.e_wdata);
        chk("inst_resp",  idx, LW'(inst_pmem_resp), LW'(r.e_iresp));
        chk("data_resp",  idx, LW'(data_pmem_resp), LW'(r.e_dresp));
        chk("inst_rdata", idx, inst_pmem_rdata,     r.m_rdata);
        chk("data_rdata", idx, data_pmem_rdata,     r.m_rdata);
        chk("state",      idx, LW'(o_dbg_state),    LW'(r.e_state));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        inst_pmem_read = 1'b0; inst_pmem_address = '0;
        data_pmem_read = 1'b0; data_pmem_write = 1'b0;
        data_pmem_address = '0; data_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (2) @(posedge clk);

        // Post-reset state, then single I read answered after 5 cycles.
        vq.push_back(v(1, 0, 32'h0,      0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h0,      L_Z, 0, 0, S_IDLE));
        vq.push_back(v(0, 1, 32'h1000,   0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h0,      L_Z, 0, 0, S_IDLE));
        for (int k = 0; k < 4; k++)
            vq.push_back(v(0, 1, 32'h1000, 0, 0, 32'h0, L_Z, 0, L_Z, 1, 0, 32'h1000, L_Z, 0, 0, S_SI));
        vq.push_back(v(0, 1, 32'h1000,   0, 0, 32'h0, L_Z, 1, L_AA, 1, 0, 32'h1000,   L_Z, 1, 0, S_SI));
        vq.push_back(v(0, 0, 32'h0,      0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h1000,   L_Z, 0, 0, S_IDLE));
        // D write; requester changes its address mid-transaction.
        vq.push_back(v(0, 0, 32'h0, 0, 1, 32'h2000, L_55, 0, L_Z, 0, 0, 32'h1000, L_Z,  0, 0, S_IDLE));
        vq.push_back(v(0, 0, 32'h0, 0, 1, 32'h3000, L_55, 0, L_Z, 0, 1, 32'h2000, L_55, 0, 0, S_SD));
        vq.push_back(v(0, 0, 32'h0, 0, 1, 32'h3000, L_55, 0, L_Z, 0, 1, 32'h2000, L_55, 0, 0, S_SD));
        vq.push_back(v(0, 0, 32'h0, 0, 1, 32'h3000, L_55, 1, L_Z, 0, 1, 32'h2000, L_55, 0, 1, S_SD));
        vq.push_back(v(0, 0, 32'h0, 0, 0, 32'h0,    L_Z,  0, L_Z, 0, 0, 32'h2000, L_55, 0, 0, S_IDLE));
        // Reset, then I and D together: D first, I chained with no idle gap.
        vq.push_back(v(1, 0, 32'h0,    0, 0, 32'h0,    L_Z, 0, L_Z,  0, 0, 32'h2000, L_55, 0, 0, S_IDLE));
        vq.push_back(v(0, 1, 32'h1100, 1, 0, 32'h2200, L_Z, 0, L_Z,  0, 0, 32'h0,    L_Z,  0, 0, S_IDLE));
        vq.push_back(v(0, 1, 32'h1100, 1, 0, 32'h2200, L_Z, 0, L_Z,  1, 0, 32'h2200, L_Z,  0, 0, S_SD));
        vq.push_back(v(0, 1, 32'h1100, 1, 0, 32'h2200, L_Z, 1, L_CC, 1, 0, 32'h2200, L_Z,  0, 1, S_SD));
        vq.push_back(v(0, 1, 32'h1100, 0, 0, 32'h0,    L_Z, 0, L_Z,  1, 0, 32'h1100, L_Z,  0, 0, S_SI));
        vq.push_back(v(0, 1, 32'h1100, 0, 0, 32'h0,    L_Z, 1, L_33, 1, 0, 32'h1100, L_Z,  1, 0, S_SI));
        vq.push_back(v(0, 0, 32'h0,    0, 0, 32'h0,    L_Z, 0, L_Z,  0, 0, 32'h1100, L_Z,  0, 0, S_IDLE));
        // D read+write together is a write; stray pmem_resp in IDLE is ignored.
        vq.push_back(v(0, 0, 32'h0, 1, 1, 32'h4000, L_0F, 0, L_Z,  0, 0, 32'h1100, L_Z,  0, 0, S_IDLE));
        vq.push_back(v(0, 0, 32'h0, 1, 1, 32'h4000, L_0F, 1, L_AA, 0, 1, 32'h4000, L_0F, 0, 1, S_SD));
        vq.push_back(v(0, 0, 32'h0, 0, 0, 32'h0,    L_Z,  1, L_55, 0, 0, 32'h4000, L_0F, 0, 0, S_IDLE));
        // last_grant is D now: I wins the tie, D write chained after it.
        vq.push_back(v(0, 1, 32'h5000, 0, 1, 32'h6000, L_12, 0, L_Z,  0, 0, 32'h4000, L_0F, 0, 0, S_IDLE));
        vq.push_back(v(0, 1, 32'h5000, 0, 1, 32'h6000, L_12, 1, L_CC, 1, 0, 32'h5000, L_Z,  1, 0, S_SI));
        vq.push_back(v(0, 0, 32'h0,    0, 1, 32'h6000, L_12, 0, L_Z,  0, 1, 32'h6000, L_12, 0, 0, S_SD));
        vq.push_back(v(0, 0, 32'h0,    0, 1, 32'h6000, L_12, 1, L_33, 0, 1, 32'h6000, L_12, 0, 1, S_SD));
        vq.push_back(v(0, 0, 32'h0,    0, 0, 32'h0,    L_Z,  0, L_Z,  0, 0, 32'h6000, L_12, 0, 0, S_IDLE));
        // I request dropped mid-transaction still completes.
        vq.push_back(v(0, 1, 32'h7000, 0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h6000, L_12, 0, 0, S_IDLE));
        vq.push_back(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 0, L_Z,  1, 0, 32'h7000, L_Z,  0, 0, S_SI));
        vq.push_back(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 1, L_AA, 1, 0, 32'h7000, L_Z,  1, 0, S_SI));
        vq.push_back(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h7000, L_Z,  0, 0, S_IDLE));

        foreach (vq[i]) apply(vq[i], i);

        // Hand sequence: reset in cycle 3 of an I read, memory answers late.
        apply(v(0, 1, 32'h8000, 0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h7000, L_Z, 0, 0, S_IDLE), 100);
        apply(v(0, 1, 32'h8000, 0, 0, 32'h0, L_Z, 0, L_Z,  1, 0, 32'h8000, L_Z, 0, 0, S_SI),   101);
        apply(v(0, 1, 32'h8000, 0, 0, 32'h0, L_Z, 0, L_Z,  1, 0, 32'h8000, L_Z, 0, 0, S_SI),   102);
        apply(v(1, 1, 32'h8000, 0, 0, 32'h0, L_Z, 0, L_Z,  1, 0, 32'h8000, L_Z, 0, 0, S_SI),   103);
        apply(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h0,    L_Z, 0, 0, S_IDLE), 104);
        apply(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h0,    L_Z, 0, 0, S_IDLE), 105);
        apply(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 1, L_AA, 0, 0, 32'h0,    L_Z, 0, 0, S_IDLE), 106);
        apply(v(0, 0, 32'h0,    0, 0, 32'h0, L_Z, 0, L_Z,  0, 0, 32'h0,    L_Z, 0, 0, S_IDLE), 107);

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
